// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory load/store master: access sizes,
// FSM states and the byte-enable helper used by the lane aligner.
package dm_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    // Size encoding 2'b11 is treated as a word access, like 2'b00.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store-side replication and byte enables,
// load-side lane extraction with sign or zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be_o = be_for(size_i, lo_i);

        case (size_i)
            SIZE_BYTE: st_data_o = {4{st_data_i[7:0]}};
            SIZE_HALF: st_data_o = {2{st_data_i[15:0]}};
            default:   st_data_o = st_data_i;
        endcase

        case (lo_i)
            2'd0:    byte_sel = ld_word_i[7:0];
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            default: byte_sel = ld_word_i[31:24];
        endcase
        half_sel = lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        case (size_i)
            SIZE_BYTE: ld_data_o = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            SIZE_HALF: ld_data_o = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default:   ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/dm_load_store_master.sv
// MEM-stage initiator for the data-memory bus: one outstanding load/store,
// alignment/range check, bus handshake with a WAIT timeout, extended load data.
module dm_load_store_master
    import dm_pkg::*;
#(
    parameter int DM_WORDS    = 3072,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    // Request side: a request is taken on the edge where req_valid_i && req_ready_o.
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic [31:0] rsp_pc_o,
    // Bus side: bus_req_o holds until the edge where bus_gnt_i is high.
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic [1:0]  dbg_state_o
);

    localparam logic [29:0] DM_WORDS_W = 30'(DM_WORDS);
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    dm_state_e   state_q;
    logic        req_ready_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lo_q;
    logic [31:0] pc_q;
    logic [7:0]  cnt_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] rsp_pc_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        in_idle;
    logic        accept;
    logic [1:0]  sel_size;
    logic        sel_signed;
    logic [1:0]  sel_lo;
    logic        misaligned;
    logic        out_of_range;
    logic        bad_req;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = req_valid_i && req_ready_q;

    // In IDLE the aligner looks at the live request so bus fields can be
    // registered on the accept edge; afterwards it works from the latches.
    assign sel_size   = in_idle ? req_size_i   : size_q;
    assign sel_signed = in_idle ? req_signed_i : signed_q;
    assign sel_lo     = in_idle ? req_addr_i[1:0] : lo_q;

    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = req_addr_i[0];
            default:   misaligned = (req_addr_i[1:0] != 2'b00);
        endcase
        out_of_range = (req_addr_i[31:2] >= DM_WORDS_W);
        bad_req      = misaligned || out_of_range;
    end

    dm_lane_align u_align (
        .size_i    (sel_size),
        .signed_i  (sel_signed),
        .lo_i      (sel_lo),
        .st_data_i (req_wdata_i),
        .ld_word_i (bus_rdata_i),
        .st_be_o   (st_be),
        .st_data_o (st_data),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            lo_q        <= 2'd0;
            pc_q        <= 32'd0;
            cnt_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_pc_q    <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        signed_q    <= req_signed_i;
                        lo_q        <= req_addr_i[1:0];
                        pc_q        <= req_pc_i;
                        req_ready_q <= 1'b0;
                        if (bad_req) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            rsp_pc_q    <= req_pc_i;
                        end else begin
                            state_q     <= ST_ISSUE;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= req_we_i;
                            bus_addr_q  <= {req_addr_i[31:2], 2'b00};
                            bus_be_q    <= req_we_i ? st_be : 4'b1111;
                            bus_wdata_q <= st_data;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= 8'd0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion arriving in the timeout cycle still counts.
                    if (bus_rvalid_i) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'd0 : ld_data;
                        rsp_pc_q    <= pc_q;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                        rsp_pc_q    <= pc_q;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_pc_o    = rsp_pc_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_load_store_master.sv
// Directed bench for dm_load_store_master: table of load/store vectors with
// hand-computed bus and response values, plus timeout and reset sequences.
module tb_dm_load_store_master;

    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic [31:0] req_pc_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] rsp_pc_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;
    logic [1:0]  dbg_state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [31:0] rsp;
    } vec_t;

    vec_t vecs[14];

    dm_load_store_master #(.DM_WORDS(3072), .TIMEOUT_CYC(TMO)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_pc_i     (req_pc_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_pc_o     (rsp_pc_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] pc);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_size_i   = size;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_pc_i     = pc;
        @(negedge CLK);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_size_i  = 2'($urandom_range(0, 3));
        req_pc_i    = $urandom;
    endtask

    // Entered and left at a negedge in IDLE, so consecutive calls are back-to-back.
    task automatic run_vec(input vec_t v, input logic [31:0] pc, input int gd, input int rd,
                           input string tag);
        check({tag, " ready_idle"}, req_ready_o, 1);
        drive_req(v.we, v.size, v.sgn, v.addr, v.wdata, pc);
        if (v.err) begin
            check({tag, " err_rsp_valid"}, rsp_valid_o, 1);
            check({tag, " err_rsp_err"}, rsp_err_o, 1);
            check({tag, " err_rsp_rdata"}, rsp_rdata_o, 0);
            check({tag, " err_rsp_pc"}, rsp_pc_o, pc);
            check({tag, " err_no_bus_req"}, bus_req_o, 0);
            @(negedge CLK);
            check({tag, " err_rsp_drop"}, rsp_valid_o, 0);
            check({tag, " err_bus_idle"}, bus_req_o, 0);
        end else begin
            check({tag, " bus_req"}, bus_req_o, 1);
            check({tag, " bus_we"}, bus_we_o, v.we);
            check({tag, " bus_addr"}, bus_addr_o, v.baddr);
            check({tag, " bus_be"}, bus_be_o, v.be);
            if (v.we) check({tag, " bus_wdata"}, bus_wdata_o, v.bwdata);
            for (int i = 0; i < gd; i++) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = $urandom;
                @(negedge CLK);
            end
            bus_rvalid_i = 1'b0;
            check({tag, " bus_req_held"}, bus_req_o, 1);
            check({tag, " no_rsp_in_issue"}, rsp_valid_o, 0);
            bus_gnt_i = 1'b1;
            @(negedge CLK);
            bus_gnt_i = 1'b0;
            check({tag, " bus_req_drop"}, bus_req_o, 0);
            for (int i = 0; i < rd; i++) begin
                bus_rdata_i = $urandom;
                @(negedge CLK);
            end
            check({tag, " no_rsp_in_wait"}, rsp_valid_o, 0);
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = v.rdata;
            @(negedge CLK);
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
            check({tag, " rsp_valid"}, rsp_valid_o, 1);
            check({tag, " rsp_err"}, rsp_err_o, 0);
            check({tag, " rsp_rdata"}, rsp_rdata_o, v.rsp);
            check({tag, " rsp_pc"}, rsp_pc_o, pc);
        end
        @(negedge CLK);
        check({tag, " rsp_pulse_one"}, rsp_valid_o, 0);
        check({tag, " rsp_rdata_hold"}, rsp_rdata_o, v.err ? 32'd0 : v.rsp);
    endtask

    initial begin
        //          we    size   sgn   addr          wdata         rdata         err   be       bwdata        baddr         rsp
        vecs[0]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_56AB, 32'hDEAD_BEEF, 1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0000_0004, 32'h0};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0,         32'h80FF_0000, 1'b0, 4'b1111, 32'h0,         32'h0000_0000, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,         32'h80FF_0000, 1'b0, 4'b1111, 32'h0,         32'h0000_0000, 32'h0000_80FF};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_3000, 32'h1111_2222, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_2FFC, 32'h0};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h0000_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0010, 32'h0};
        vecs[7]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0,         32'h1234_F00D, 1'b0, 4'b1111, 32'h0,         32'h0000_0100, 32'hFFFF_F00D};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         32'h1234_F0A5, 1'b0, 4'b1111, 32'h0,         32'h0000_0100, 32'h0000_00F0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0005, 32'h0000_7777, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[10] = '{1'b0, 2'b11, 1'b1, 32'h0000_0008, 32'h0,         32'h89AB_CDEF, 1'b0, 4'b1111, 32'h0,         32'h0000_0008, 32'h89AB_CDEF};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h0000_0041, 32'h0,         32'h0000_7F00, 1'b0, 4'b1111, 32'h0,         32'h0000_0040, 32'h0000_007F};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h0000_005A, 32'h0,         1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0004, 32'h0};
        vecs[13] = '{1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};

        // Clock/reset
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("reset ready", req_ready_o, 1);
        check("reset rsp_valid", rsp_valid_o, 0);
        check("reset bus_req", bus_req_o, 0);
        check("reset bus_be", bus_be_o, 0);
        check("reset rsp_pc", rsp_pc_o, 0);
        check("reset state", dbg_state_o, 0);

        // Table, back-to-back
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], 32'h0040_0000 + 32'(i * 4), i % 3, (i + 1) % 4, $sformatf("vec%0d", i));
        end

        // Timeout: grant after 5 cycles, then no completion
        begin
            int cnt;
            drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_1000);
            repeat (5) @(negedge CLK);
            check("tmo bus_req_held", bus_req_o, 1);
            bus_gnt_i = 1'b1;
            @(negedge CLK);
            bus_gnt_i = 1'b0;
            cnt = 0;
            while (!rsp_valid_o && cnt < 300) begin
                @(negedge CLK);
                cnt++;
            end
            check("tmo cycles_after_gnt", cnt, TMO);
            check("tmo rsp_err", rsp_err_o, 1);
            check("tmo rsp_rdata", rsp_rdata_o, 0);
            check("tmo rsp_pc", rsp_pc_o, 32'h0000_1000);
            @(negedge CLK);
        end

        // Completion in the final WAIT cycle beats the timeout
        begin
            drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_1004);
            repeat (5) @(negedge CLK);
            bus_gnt_i = 1'b1;
            @(negedge CLK);
            bus_gnt_i = 1'b0;
            repeat (TMO - 1) @(negedge CLK);
            check("late no_rsp_before_last", rsp_valid_o, 0);
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = 32'h1357_9BDF;
            @(negedge CLK);
            bus_rvalid_i = 1'b0;
            check("late rsp_valid", rsp_valid_o, 1);
            check("late rsp_err", rsp_err_o, 0);
            check("late rsp_rdata", rsp_rdata_o, 32'h1357_9BDF);
            @(negedge CLK);
        end

        // RESET while in WAIT, then a stray completion
        begin
            drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_2000);
            bus_gnt_i = 1'b1;
            @(negedge CLK);
            bus_gnt_i = 1'b0;
            repeat (3) @(negedge CLK);
            check("rst in_wait", dbg_state_o, 2);
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            check("rst state_idle", dbg_state_o, 0);
            check("rst ready", req_ready_o, 1);
            check("rst bus_req", bus_req_o, 0);
            check("rst no_rsp", rsp_valid_o, 0);
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = 32'hFFFF_FFFF;
            @(negedge CLK);
            bus_rvalid_i = 1'b0;
            check("rst late_rvalid_no_rsp", rsp_valid_o, 0);
            check("rst late_rvalid_idle", dbg_state_o, 0);
            check("rst rdata_cleared", rsp_rdata_o, 0);
        end

        run_vec(vecs[0], 32'h0050_0000, 0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
